prog_sequencer: RTL and testbench
=================================

// Module: prog_sequencer
// PURPOSE
//  Run controller for the instruction-fetch stage. It steps the fetch unit through programs 0..NUM_PROGS-1.
//  For each program it drives Init with the matching ProgState, waits for the fetch unit's Halt, and records the cycle count.
//  It reports completion through a Done/Ack handshake. It sits between the testbench/top-level start logic and IF.
// PARAMETERS
//  NUM_PROGS  3        number of programs run per Start (1..3)
//  PS_W       2        width of ProgState
//  CNT_W      16       width of cycle counters
//  TIMEOUT    16'hFFFF RUN-cycle limit per program (watchdog only)
// PORTS
//  CLK        in   1      clock; all state changes on posedge
//  Reset_n    in   1      asynchronous, active-low reset
//  Start      in   1      level/pulse; sampled only in IDLE
//  Abort      in   1      return to IDLE from any state
//  Halt       in   1      done flag from fetch unit
//  Ack        in   1      acknowledges Done
//  Init       out  1      init strobe to fetch unit
//  ProgState  out  PS_W   program select to fetch unit
//  Busy       out  1      high in every state except IDLE and DONE
//  ProgDone   out  1      1-cycle pulse when a program finishes
//  LastCycles out  CNT_W  RUN-cycle count of the most recent program
//  TotalCycles out CNT_W  sum of LastCycles for the current Start; saturating
//  Done       out  1      all programs finished; held until Ack
//  Timeout    out  1      sticky watchdog flag; 0 when watchdog is compiled out
// BEHAVIOUR
//  Reset (async, Reset_n=0): state=IDLE, idx=0, ProgState=2'b11, and all other outputs =0.
//  States and transitions:
//   IDLE:   ProgState=2'b11 (free-run), Init=0. On Start=1: idx=0, clear TotalCycles and Timeout, go to INIT.
//   INIT:   Init=1 and ProgState=idx for exactly one cycle; clear run counter; go to SETTLE.
//   SETTLE: Init=0, ProgState=idx; Halt is ignored (IF's Halt lags one cycle); go to RUN.
//   RUN:    run counter +1 per cycle, saturating at all-ones. On Halt=1, go to RECORD.
//   RECORD: LastCycles<=run counter; TotalCycles<=TotalCycles+run counter, saturating; ProgDone=1 (this cycle only).
//           If idx==NUM_PROGS-1, go to DONE; else idx+1 and go to INIT.
//   DONE:   Done=1, ProgState=2'b11. On Ack=1, go to IDLE (Done drops next cycle).
//  - Latency: Start to first Init is 1 cycle. Halt sampled in RUN produces ProgDone 1 cycle later.
//  - Between programs: RECORD->INIT is back-to-back, with no idle cycle.
//  - Start outside IDLE is ignored. Ack outside DONE is ignored.
//  - A Start in the cycle after Ack is accepted normally.
//  - Abort=1 in any non-IDLE state: next state IDLE, with Init=0, ProgState=2'b11 and Done=0.
//    LastCycles and TotalCycles are held. Abort beats Halt, Ack and the watchdog in the same cycle.
//  - Counter arithmetic is unsigned CNT_W; all sums saturate and never wrap.
//  - Reset mid-run: immediate return to the reset values above, no ProgDone pulse.
//  - idx is PS_W bits wide; ProgState=idx only in INIT, SETTLE, RUN and RECORD.
// CONFIGURATION
//  Macro SEQ_WATCHDOG_EN:
//   Defined: in RUN, if the run counter reaches TIMEOUT with Halt=0, treat it as a Halt.
//    Timeout<=1 (sticky until the next accepted Start), go to RECORD with LastCycles=TIMEOUT, and continue with the next program.
//    Halt and timeout in the same cycle: counts as a normal Halt; Timeout is not set.
//   Undefined: no watchdog. RUN waits indefinitely for Halt; the counter saturates; Timeout is tied to 0.
// TESTING
//  1. Reset_n low mid-RUN -> Init=0, ProgState=2'b11, Busy=0, Done=0 asynchronously.
//  2. Start; IF model halts 5 RUN cycles after each Init -> 3 ProgDone pulses, LastCycles=5 each;
//     TotalCycles=15; Done=1 until Ack; ProgState sequence 00,01,10 then 11.
//  3. Start held high through whole run; Ack and Start both high in DONE -> IDLE,
//     then a new run starting the next cycle with TotalCycles cleared.
//  4. Abort asserted in RUN of program 1 with Halt=1 same cycle -> IDLE, no ProgDone,
//     LastCycles keeps program 0 value.
//  5. CNT_W=4, Halt after 20 cycles (watchdog off) -> LastCycles=4'hF, TotalCycles saturates at 4'hF.
//  6. SEQ_WATCHDOG_EN, TIMEOUT=8, program 1 never halts -> Timeout=1, LastCycles=8,
//     program 2 still runs, Done=1.

Source files
------------

// File: rtl/prog_sequencer.sv
// prog_sequencer: run controller for the instruction-fetch stage.
// Steps the fetch unit through programs 0..NUM_PROGS-1: one Init pulse per
// program, waits for Halt, records per-program and total RUN-cycle counts,
// then reports completion through a Done/Ack handshake.
// Optional watchdog: define SEQ_WATCHDOG_EN to end a program that runs for
// TIMEOUT cycles without Halt (Timeout flag is sticky until the next Start).
module prog_sequencer #(
   parameter int          NUM_PROGS = 3,
   parameter int          PS_W      = 2,
   parameter int          CNT_W     = 16,
   parameter int unsigned TIMEOUT   = 32'h0000FFFF
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Abort,
   input  logic             Halt,
   input  logic             Ack,
   output logic             Init,
   output logic [PS_W-1:0]  ProgState,
   output logic             Busy,
   output logic             ProgDone,
   output logic [CNT_W-1:0] LastCycles,
   output logic [CNT_W-1:0] TotalCycles,
   output logic             Done,
   output logic             Timeout
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_INIT   = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_RECORD = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [PS_W-1:0]  LAST_IDX = PS_W'(NUM_PROGS - 1);

   logic [2:0]       state, state_nxt;
   logic [PS_W-1:0]  idx;
   logic [CNT_W-1:0] run_cnt, run_inc, tot_sum;
   logic [CNT_W:0]   tot_wide;
   logic             to_flag;
   logic             wd_hit;
   logic             abort_now;

   // Abort only has an effect once a run is underway; in IDLE Start still wins.
   assign abort_now = Abort && (state != S_IDLE);

   // Saturating run-counter increment and saturating running total.
   assign run_inc  = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + 1'b1;
   assign tot_wide = {1'b0, TotalCycles} + {1'b0, run_cnt};
   assign tot_sum  = tot_wide[CNT_W] ? CNT_MAX : tot_wide[CNT_W-1:0];

`ifdef SEQ_WATCHDOG_EN
   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
   // A real Halt in the limit cycle takes precedence, so no timeout then.
   assign wd_hit = (state == S_RUN) && !Halt && (run_inc == TO_LIM);
`else
   assign wd_hit = 1'b0;
`endif

   // Next-state selection; Abort overrides every other input.
   always_comb begin
      state_nxt = state;
      if (abort_now) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   if (Start) state_nxt = S_INIT;
            S_INIT:   state_nxt = S_SETTLE;
            S_SETTLE: state_nxt = S_RUN;   // IF's Halt lags a cycle; ignore it here
            S_RUN:    if (Halt || wd_hit) state_nxt = S_RECORD;
            S_RECORD: state_nxt = (idx == LAST_IDX) ? S_DONE : S_INIT;
            S_DONE:   if (Ack) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Program index, counters and watchdog flag; all held across an Abort.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         idx         <= '0;
         run_cnt     <= '0;
         LastCycles  <= '0;
         TotalCycles <= '0;
         to_flag     <= 1'b0;
      end else if (!abort_now) begin
         case (state)
            S_IDLE: if (Start) begin
               idx         <= '0;
               TotalCycles <= '0;
               to_flag     <= 1'b0;
            end
            S_INIT: run_cnt <= '0;
            S_RUN: begin
               run_cnt <= run_inc;
               if (wd_hit) to_flag <= 1'b1;
            end
            S_RECORD: begin
               LastCycles  <= run_cnt;
               TotalCycles <= tot_sum;
               if (idx != LAST_IDX) idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Moore-style output decode; ProgDone is suppressed if aborted in RECORD.
   always_comb begin
      Init      = (state == S_INIT);
      Busy      = (state != S_IDLE) && (state != S_DONE);
      Done      = (state == S_DONE);
      ProgDone  = (state == S_RECORD) && !Abort;
      ProgState = '1;
      if (Busy) ProgState = idx;
   end

   assign Timeout = to_flag;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer. A fetch-unit model answers each Init
// with Halt after a chosen number of RUN cycles; expectations come from a
// per-run arithmetic model and are checked by a negedge monitor.
module tb_prog_sequencer;
   localparam int NP   = 3;
   localparam int PSW  = 2;
   localparam int CW   = 6;
   localparam int TO   = 40;
   localparam int MAXC = (1 << CW) - 1;
`ifdef SEQ_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic           CLK = 0, Reset_n = 0, Start = 0, Abort = 0, Halt = 0, Ack = 0;
   logic           Init, Busy, ProgDone, Done, Timeout;
   logic [PSW-1:0] ProgState;
   logic [CW-1:0]  LastCycles, TotalCycles;

   prog_sequencer #(.NUM_PROGS(NP), .PS_W(PSW), .CNT_W(CW), .TIMEOUT(TO)) dut (
      .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Abort(Abort), .Halt(Halt),
      .Ack(Ack), .Init(Init), .ProgState(ProgState), .Busy(Busy),
      .ProgDone(ProgDone), .LastCycles(LastCycles), .TotalCycles(TotalCycles),
      .Done(Done), .Timeout(Timeout));

   always #5 CLK = ~CLK;

   int errors = 0, checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   typedef struct { int ps; int last; int tot; int to; } rec_t;
   rec_t rec_q[$];
   rec_t done_q[$];
   int   init_q[$];

   // Fetch-unit model: Halt in RUN cycle delays[ps]; random Halt noise in
   // INIT/SETTLE (must be ignored); optional Abort coincident with Halt.
   int delays[NP];
   bit abort_en = 0;
   int abort_prog = 0;
   int if_cnt = -1, if_h = 0, if_ps = 0;
   always @(posedge CLK) begin
      #1;
      Halt  = 0;
      Abort = 0;
      if (!Reset_n) if_cnt = -1;
      else if (Init) begin
         if_cnt = 0;
         if_ps  = int'(ProgState);
         if_h   = delays[if_ps];
         Halt   = 1'($urandom % 2);
      end else if (if_cnt >= 0) begin
         if_cnt++;
         if (if_cnt == 1) Halt = 1'($urandom % 2);
         else if (if_cnt - 1 == if_h) begin
            Halt   = 1;
            if_cnt = -1;
            if (abort_en && if_ps == abort_prog) Abort = 1;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents Init, ProgDone or Done.
   bit   pd_d = 0, done_d = 0;
   rec_t mr;
   always @(negedge CLK) begin
      if (Reset_n) begin
         if (Init) begin
            if (init_q.size() == 0) flag("unexpected_init");
            else chk("init_progstate", 32'(ProgState), init_q.pop_front());
         end
         if (ProgDone) begin
            if (rec_q.size() == 0) flag("unexpected_progdone");
            else chk("progdone_progstate", 32'(ProgState), rec_q[0].ps);
         end
         if (pd_d && rec_q.size() != 0) begin
            mr = rec_q.pop_front();
            chk("last_cycles", 32'(LastCycles), mr.last);
            chk("total_cycles", 32'(TotalCycles), mr.tot);
            chk("timeout_flag", 32'(Timeout), mr.to);
         end
         if (Done && !done_d) begin
            if (done_q.size() == 0) flag("unexpected_done");
            else begin
               mr = done_q.pop_front();
               chk("done_total", 32'(TotalCycles), mr.tot);
               chk("done_timeout", 32'(Timeout), mr.to);
               chk("done_progstate", 32'(ProgState), 3);
               chk("done_busy", 32'(Busy), 0);
            end
         end
      end
      pd_d   = ProgDone;
      done_d = Done;
   end

   // Reference model for one Start: per-program recorded count, saturating
   // total, and sticky watchdog flag. abort_p >= 0 stops at that program.
   task automatic model_run(input int d[NP], input int abort_p);
      int tot = 0, to = 0, rec;
      for (int p = 0; p < NP; p++) begin
         init_q.push_back(p);
         if (p == abort_p) break;
         if (WD && d[p] > TO) begin rec = TO; to = 1; end
         else rec = (d[p] > MAXC) ? MAXC : d[p];
         tot = (tot + rec > MAXC) ? MAXC : tot + rec;
         rec_q.push_back('{p, rec, tot, to});
      end
      if (abort_p < 0) done_q.push_back('{3, 0, tot, to});
      delays = d;
   endtask

   task automatic start_pulse(input bit hold);
      @(posedge CLK); #1;
      Start = 1;
      @(posedge CLK); #1;
      if (!hold) Start = 0;
      chk("start_to_init", 32'(Init), 1);
   endtask

   task automatic wait_done(input bit hold);
      int n = 0;
      while (!Done && n < 600) begin
         @(posedge CLK); #1;
         if (!hold) Start = Busy ? 1'($urandom % 2) : 1'b0;
         n++;
      end
      if (!Done) flag("done_wait_expired");
   endtask

   task automatic ack_done();
      repeat (2) begin
         @(posedge CLK); #1;
         chk("done_held", 32'(Done), 1);
      end
      Ack = 1;
      @(posedge CLK); #1;
      Ack = 0;
      chk("after_ack_done", 32'(Done), 0);
      chk("after_ack_busy", 32'(Busy), 0);
      chk("after_ack_progstate", 32'(ProgState), 3);
      chk("queues_drained", 32'(rec_q.size() + init_q.size() + done_q.size()), 0);
   endtask

   task automatic full_run(input int d[NP]);
      model_run(d, -1);
      start_pulse(0);
      wait_done(0);
      ack_done();
   endtask

   initial begin
      int d[NP];
      int n;
      // Reset state
      #12;
      chk("rst_init", 32'(Init), 0);
      chk("rst_progstate", 32'(ProgState), 3);
      chk("rst_busy", 32'(Busy), 0);
      chk("rst_done", 32'(Done), 0);
      chk("rst_progdone", 32'(ProgDone), 0);
      chk("rst_last", 32'(LastCycles), 0);
      chk("rst_total", 32'(TotalCycles), 0);
      chk("rst_timeout", 32'(Timeout), 0);
      @(posedge CLK); #1;
      Reset_n = 1;

      // Basic run, shortest halts, and counter saturation
      d = '{5, 5, 5};   full_run(d);
      d = '{1, 2, 1};   full_run(d);
      d = '{40, 40, 70}; full_run(d);

      // Start held through a run; Ack and Start together restart at once
      d = '{3, 7, 4};
      model_run(d, -1);
      start_pulse(1);
      wait_done(1);
      @(posedge CLK); #1;
      chk("held_start_done", 32'(Done), 1);
      d = '{6, 2, 9};
      model_run(d, -1);
      Ack = 1;
      @(posedge CLK); #1;
      Ack = 0;
      chk("ack_start_idle", 32'(Busy), 0);
      @(posedge CLK); #1;
      Start = 0;
      chk("restart_init", 32'(Init), 1);
      chk("restart_total_clear", 32'(TotalCycles), 0);
      wait_done(0);
      ack_done();

      // Abort coincident with Halt in program 1
      d = '{$urandom_range(1, 30), 4, 9};
      model_run(d, 1);
      abort_en = 1; abort_prog = 1;
      start_pulse(0);
      n = 0;
      while (Busy && n < 300) begin @(posedge CLK); #1; n++; end
      if (Busy) flag("abort_wait_expired");
      abort_en = 0;
      chk("abort_progstate", 32'(ProgState), 3);
      chk("abort_init", 32'(Init), 0);
      chk("abort_done", 32'(Done), 0);
      chk("abort_last_held", 32'(LastCycles), d[0]);
      chk("abort_total_held", 32'(TotalCycles), d[0]);
      repeat (3) @(posedge CLK);
      #1;
      chk("abort_queues", 32'(rec_q.size() + init_q.size()), 0);

      // Randomized runs
      for (int r = 0; r < 6; r++) begin
         for (int p = 0; p < NP; p++) d[p] = $urandom_range(1, 45);
         full_run(d);
      end

      // Asynchronous reset in the middle of RUN
      d = '{10, 10, 10};
      model_run(d, -1);
      start_pulse(0);
      repeat (5) @(posedge CLK);
      #2;
      Reset_n = 0;
      #1;
      chk("midrun_rst_init", 32'(Init), 0);
      chk("midrun_rst_progstate", 32'(ProgState), 3);
      chk("midrun_rst_busy", 32'(Busy), 0);
      chk("midrun_rst_done", 32'(Done), 0);
      chk("midrun_rst_progdone", 32'(ProgDone), 0);
      chk("midrun_rst_last", 32'(LastCycles), 0);
      chk("midrun_rst_total", 32'(TotalCycles), 0);
      rec_q.delete(); init_q.delete(); done_q.delete();
      @(posedge CLK); #1;
      Reset_n = 1;
      repeat (3) @(posedge CLK);
      #1;
      chk("post_rst_idle", 32'(Busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
